aes_inv_key_gen: RTL and testbench

// - Inverse AES-128 key schedule for the decryption datapath.
// - Takes the final (round-10) round key and emits round keys 10, 9, ... 0 in descending order.
// - Delivers the keys to the inverse cipher over a valid/ready handshake.
// - Mirrors the forward key expansion: shares the external S-box through a sub-word request/return port pair.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_inv_key_step.sv | 30 +++
 rtl/aes_inv_key_gen.sv | 91 +++++++++
 tb/tb_aes_inv_key_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, round constants and inverse key-schedule FSM encoding.
// RCON is shared with the forward key generator.
package aes_pkg;

   typedef logic [31:0]  aes_word;
   typedef logic [127:0] aes_128;

   localparam int unsigned AES128_ROUNDS = 10;

   localparam logic [7:0] RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT
   } inv_kg_state_e;

   // Indices past the table return 0 so callers never read out of range.
   function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
      logic [7:0] r;
      r = '0;
      if (idx < 4'd10) r = RCON[idx];
      return r;
   endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// Combinational inverse AES-128 round-key step: round r key -> round r-1 key.
// The SubWord lookup is done by an external S-box via sub_o/sub_i.
module aes_inv_key_step
   import aes_pkg::*;
(
   input  aes_128     key,
   input  aes_word    sub_i,
   input  logic [7:0] rcon,
   output aes_128     prev_key,
   output aes_word    sub_o
);

   aes_word w0, w1, w2, w3;
   aes_word p0, p1, p2, p3;

   always_comb begin
      w0 = key[127:96];
      w1 = key[95:64];
      w2 = key[63:32];
      w3 = key[31:0];
      p3 = w3 ^ w2;
      p2 = w2 ^ w1;
      p1 = w1 ^ w0;
      // p3 is the previous round's w3; its RotWord feeds the S-box.
      sub_o = {p3[23:0], p3[31:24]};
      p0 = w0 ^ sub_i ^ {rcon, 24'h0};
      prev_key = {p0, p1, p2, p3};
   end

endmodule

// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule: emits round keys 10..0 over valid/ready,
// using a shared external S-box for the SubWord step.
module aes_inv_key_gen
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start_i,
   input  aes_128     key_last_i,
   input  aes_word    sub_i,
   output aes_word    sub_o,
   output aes_128     key_o,
   output logic [3:0] rnd_o,
   output logic       key_valid_o,
   input  logic       key_ready_i,
   output logic       busy_o,
   output logic       done_o
);

   inv_kg_state_e state_q, state_d;
   aes_128        key_q, key_d;
   logic [3:0]    rnd_q, rnd_d;
   logic          done_q, done_d;
   aes_128        prev_key;
   logic [7:0]    rcon_sel;

   // Round 0 has no predecessor; keep the RCON index in range there.
   assign rcon_sel = (rnd_q == '0) ? '0 : aes_rcon(rnd_q - 4'd1);

   aes_inv_key_step u_step (
      .key      (key_q),
      .sub_i    (sub_i),
      .rcon     (rcon_sel),
      .prev_key (prev_key),
      .sub_o    (sub_o)
   );

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               key_d   = key_last_i;
               state_d = LOAD;
            end
         end
         LOAD: begin
            rnd_d   = 4'(NUM_ROUNDS);
            state_d = EMIT;
         end
         EMIT: begin
            if (key_ready_i) begin
               if (rnd_q != '0) begin
                  key_d = prev_key;
                  rnd_d = rnd_q - 4'd1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_q <= IDLE;
         key_q   <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   assign key_o       = key_q;
   assign rnd_o       = rnd_q;
   assign key_valid_o = (state_q == EMIT);
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Scoreboard bench for aes_inv_key_gen; provides the shared S-box and an
// independent word-array inverse key-expansion model.
module tb_aes_inv_key_gen;
   import aes_pkg::*;

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] key;
   } exp_t;

   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   localparam logic [127:0] SBOX [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   localparam logic [7:0] RC_T [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   logic         clk = 1'b0;
   logic         nrst = 1'b1;
   logic         start_i = 1'b0;
   logic [127:0] key_last_i = '0;
   logic [31:0]  sub_i;
   logic [31:0]  sub_o;
   logic [127:0] key_o;
   logic [3:0]   rnd_o;
   logic         key_valid_o;
   logic         key_ready_i = 1'b1;
   logic         busy_o;
   logic         done_o;

   int total = 0;
   int bad   = 0;
   exp_t sb[$];
   logic [127:0] mdl [11];

   always #5 clk = ~clk;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [127:0] row;
      row = SBOX[b[7:4]];
      return row[(15 - int'(b[3:0])) * 8 +: 8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   assign sub_i = subw(sub_o);

   aes_inv_key_gen #(.NUM_ROUNDS(10)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .start_i     (start_i),
      .key_last_i  (key_last_i),
      .sub_i       (sub_i),
      .sub_o       (sub_o),
      .key_o       (key_o),
      .rnd_o       (rnd_o),
      .key_valid_o (key_valid_o),
      .key_ready_i (key_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   // Walk the expanded word array backwards: w[i-4] = w[i] ^ temp(w[i-1]).
   task automatic push_expect(input logic [127:0] k10);
      logic [31:0] w [44];
      logic [31:0] t;
      exp_t e;
      for (int j = 0; j < 44; j++) w[j] = '0;
      w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
      for (int i = 43; i >= 4; i--) begin
         t = w[i-1];
         if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {RC_T[i/4 - 1], 24'h0};
         w[i-4] = w[i] ^ t;
      end
      for (int r = 10; r >= 0; r--) begin
         mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         e.rnd = 4'(r);
         e.key = mdl[r];
         sb.push_back(e);
      end
   endtask

   task automatic do_start(input logic [127:0] k);
      @(negedge clk);
      start_i = 1'b1;
      key_last_i = k;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic drain(input int stall_rnd, input int poke_rnd, output int accepts,
                        output logic [127:0] k9, output logic [127:0] k0);
      int budget;
      int stalled;
      bit poked;
      exp_t e;
      logic [131:0] held;
      accepts = 0; k9 = '0; k0 = '0; budget = 300; stalled = 0; poked = 1'b0; held = '0;
      while (sb.size() > 0 && budget > 0) begin
         if (start_i) start_i = 1'b0;
         key_ready_i = 1'b1;
         if (stall_rnd >= 0 && key_valid_o && rnd_o == 4'(stall_rnd) && stalled < 3) begin
            key_ready_i = 1'b0;
            stalled++;
            if (stalled == 1) held = {rnd_o, key_o};
            else begin
               total++;
               if ({rnd_o, key_o} !== held) begin
                  bad++;
                  $display("FAIL stall_hold: got %h expected %h", {rnd_o, key_o}, held);
               end
            end
         end
         if (poke_rnd >= 0 && !poked && key_valid_o && rnd_o == 4'(poke_rnd)) begin
            start_i = 1'b1;
            key_last_i = {$urandom, $urandom, $urandom, $urandom};
            poked = 1'b1;
         end
         if (key_valid_o && key_ready_i) begin
            e = sb.pop_front();
            total++;
            if ({rnd_o, key_o} !== {e.rnd, e.key}) begin
               bad++;
               $display("FAIL key_seq: got rnd=%0d key=%h expected rnd=%0d key=%h",
                        rnd_o, key_o, e.rnd, e.key);
            end
            accepts++;
            if (rnd_o == 4'd9) k9 = key_o;
            if (rnd_o == 4'd0) k0 = key_o;
         end
         if (sb.size() > 0) begin
            @(negedge clk);
            budget--;
         end
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d keys left expected 0", sb.size());
         sb.delete();
      end
      start_i = 1'b0;
      key_ready_i = 1'b1;
   endtask

   task automatic check_done(input string name);
      @(negedge clk);
      total++;
      if (done_o !== 1'b1) begin
         bad++;
         $display("FAIL %s_done_pulse: got %b expected 1", name, done_o);
      end
      @(negedge clk);
      total++;
      if ({done_o, busy_o} !== 2'b00) begin
         bad++;
         $display("FAIL %s_done_end: got done/busy=%b expected 00", name, {done_o, busy_o});
      end
   endtask

   task automatic test_reset;
      nrst = 1'b1;
      @(negedge clk);
      total++;
      if ({key_o, rnd_o, key_valid_o, busy_o, done_o} !== '0) begin
         bad++;
         $display("FAIL reset_vals: got %h expected 0", {key_o, rnd_o, key_valid_o, busy_o, done_o});
      end
      nrst = 1'b0;
   endtask

   task automatic test_fips;
      int acc;
      logic [127:0] k9, k0;
      push_expect(FIPS_K10);
      do_start(FIPS_K10);
      total++;
      if ({busy_o, key_valid_o} !== 2'b10) begin
         bad++;
         $display("FAIL fips_latency1: got busy/valid=%b expected 10", {busy_o, key_valid_o});
      end
      @(negedge clk);
      total++;
      if ({key_valid_o, rnd_o} !== {1'b1, 4'd10}) begin
         bad++;
         $display("FAIL fips_latency2: got valid/rnd=%h expected 1a", {key_valid_o, rnd_o});
      end
      total++;
      if (sub_o !== 32'h5c006e57) begin
         bad++;
         $display("FAIL fips_sub_o: got %h expected 5c006e57", sub_o);
      end
      drain(-1, -1, acc, k9, k0);
      total++;
      if (acc != 11 || k9 !== FIPS_K9 || k0 !== FIPS_K0) begin
         bad++;
         $display("FAIL fips_vec: got acc=%0d k9=%h k0=%h expected 11 %h %h", acc, k9, k0, FIPS_K9, FIPS_K0);
      end
      check_done("fips");
   endtask

   task automatic test_backpressure;
      int acc;
      logic [127:0] k9, k0;
      push_expect(FIPS_K10);
      do_start(FIPS_K10);
      drain(6, -1, acc, k9, k0);
      total++;
      if (acc != 11 || k0 !== FIPS_K0) begin
         bad++;
         $display("FAIL bp_accepts: got acc=%0d k0=%h expected 11 %h", acc, k0, FIPS_K0);
      end
      check_done("bp");
   endtask

   task automatic test_start_ignored;
      int acc;
      logic [127:0] k9, k0;
      push_expect(FIPS_K10);
      do_start(FIPS_K10);
      drain(-1, 4, acc, k9, k0);
      total++;
      if (acc != 11 || k0 !== FIPS_K0) begin
         bad++;
         $display("FAIL restart_ignored: got acc=%0d k0=%h expected 11 %h", acc, k0, FIPS_K0);
      end
      check_done("restart");
   endtask

   task automatic test_reset_mid;
      int acc;
      int budget;
      logic [127:0] k9, k0;
      do_start(FIPS_K10);
      budget = 50;
      while (!(key_valid_o && rnd_o == 4'd7) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      total++;
      if (budget == 0) begin
         bad++;
         $display("FAIL rstmid_reach: got rnd=%0d expected 7", rnd_o);
      end
      nrst = 1'b1;
      #1;
      total++;
      if ({key_o, rnd_o, key_valid_o, busy_o, done_o} !== '0) begin
         bad++;
         $display("FAIL rstmid_async: got %h expected 0", {key_o, rnd_o, key_valid_o, busy_o, done_o});
      end
      @(negedge clk);
      nrst = 1'b0;
      push_expect(FIPS_K10);
      do_start(FIPS_K10);
      drain(-1, -1, acc, k9, k0);
      total++;
      if (acc != 11 || k0 !== FIPS_K0) begin
         bad++;
         $display("FAIL rstmid_rerun: got acc=%0d k0=%h expected 11 %h", acc, k0, FIPS_K0);
      end
      check_done("rstmid");
   endtask

   task automatic test_back_to_back;
      int acc;
      logic [127:0] k9, k0;
      push_expect(FIPS_K10);
      do_start(FIPS_K10);
      drain(-1, -1, acc, k9, k0);
      @(negedge clk);
      total++;
      if (done_o !== 1'b1) begin
         bad++;
         $display("FAIL b2b_done: got %b expected 1", done_o);
      end
      start_i = 1'b1;
      key_last_i = '0;
      push_expect('0);
      @(negedge clk);
      start_i = 1'b0;
      drain(-1, -1, acc, k9, k0);
      total++;
      if (acc != 11 || k0 !== mdl[0]) begin
         bad++;
         $display("FAIL b2b_second: got acc=%0d k0=%h expected 11 %h", acc, k0, mdl[0]);
      end
      check_done("b2b");
   endtask

   initial begin
      test_reset();
      test_fips();
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
